// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the gate truth-table sweeper.
// Holds the sequencer state encoding, the table-width helper and the
// default gate-input count.
package tt_pkg;

  localparam int TT_DEFAULT_N_IN = 3;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SAMPLE,
    DONE
  } tt_state_e;

  // Number of rows in the truth table of an n-input gate.
  function automatic int tt_width(input int n);
    return 2 ** n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Loadable down-counter with a zero flag, used to time how long each
// input vector is held. Load has priority over decrement; the count
// saturates at zero rather than wrapping.
module tt_settle_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] count;

  // Load a new interval, otherwise count down towards zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of an N_IN-input gate in ascending order,
// holds each for SETTLE cycles, samples the output one cycle later and
// compares the assembled table against EXPECTED.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int                          N_IN     = TT_DEFAULT_N_IN,
  parameter int                          SETTLE   = 4,
  parameter logic [tt_width(N_IN)-1:0]   EXPECTED = 8'h0A
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  output logic [N_IN-1:0]           dut_in,
  input  logic                      dut_out,
  output logic                      busy,
  output logic [tt_width(N_IN)-1:0] table_out,
  output logic                      result_valid,
  output logic                      pass,
  output logic [tt_width(N_IN)-1:0] mismatch
);

  localparam int TW = tt_width(N_IN);
  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
  // idx is one bit wider than dut_in so the last-row compare never wraps.
  localparam logic [N_IN:0]   IDX_LAST = (N_IN + 1)'(TW - 1);

  tt_state_e       state;
  logic [N_IN:0]   idx;
  logic [N_IN:0]   idx_inc;
  logic [TW-1:0]   table_next;
  logic            tmr_load;
  logic            tmr_dec;
  logic            tmr_zero;

  assign idx_inc = idx + 1'b1;

  // Reload the hold interval whenever a new vector starts being driven.
  assign tmr_load = ((state == IDLE) && start && !abort) ||
                    ((state == SAMPLE) && !abort && (idx != IDX_LAST));
  assign tmr_dec  = (state == HOLD) && !abort;

  tt_settle_timer #(
    .CW(CW)
  ) u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (CNT_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Table as it will look once the current row has been captured.
  always_comb begin
    table_next = table_out;
    table_next[idx[N_IN-1:0]] = dut_out;
  end

  // Sweep sequencer; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      dut_in       <= '0;
      busy         <= 1'b0;
      table_out    <= '0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      mismatch     <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          // abort wins over a simultaneous start
          if (start && !abort) begin
            state     <= HOLD;
            idx       <= '0;
            dut_in    <= '0;
            busy      <= 1'b1;
            table_out <= '0;
            pass      <= 1'b0;
            mismatch  <= '0;
          end
        end
        HOLD: begin
          if (abort) begin
            state    <= IDLE;
            idx      <= '0;
            dut_in   <= '0;
            busy     <= 1'b0;
            pass     <= 1'b0;
            mismatch <= '0;
          end else if (tmr_zero) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (abort) begin
            // partial table is left visible for debug
            state    <= IDLE;
            idx      <= '0;
            dut_in   <= '0;
            busy     <= 1'b0;
            pass     <= 1'b0;
            mismatch <= '0;
          end else begin
            table_out <= table_next;
            if (idx == IDX_LAST) begin
              // verdict is registered together with the valid pulse
              state        <= DONE;
              busy         <= 1'b0;
              dut_in       <= '0;
              result_valid <= 1'b1;
              pass         <= (table_next == EXPECTED);
              mismatch     <= table_next ^ EXPECTED;
            end else begin
              state  <= HOLD;
              idx    <= idx_inc;
              dut_in <= idx_inc[N_IN-1:0];
            end
          end
        end
        DONE: begin
          // start and abort are both ignored here
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: golden, stuck-at and delayed gate models driven into
// two sweeper instances (SETTLE=4 and SETTLE=1), plus abort, start-while-
// busy and mid-sweep reset sequences.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, abort;
  logic [2:0] dut_in;
  logic       dut_out;
  logic       busy, result_valid, pass;
  logic [7:0] table_out, mismatch;

  logic       start_f;
  logic [2:0] dut_in_f;
  logic       dut_out_f;
  logic       busy_f, rv_f, pass_f;
  logic [7:0] table_f, mm_f;

  int mode;   // 0 golden, 1 stuck-at-1, 2 golden delayed by 3 cycles
  int passed = 0;
  int total  = 0;

  logic [2:0] d1 = '0, d2 = '0, d3 = '0;
  logic [2:0] f1 = '0, f2 = '0, f3 = '0;

  truth_table_sweeper #(.N_IN(3), .SETTLE(4), .EXPECTED(8'h0A)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .table_out(table_out),
    .result_valid(result_valid), .pass(pass), .mismatch(mismatch)
  );

  truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'h0A)) u_fast (
    .clk(clk), .reset(reset), .start(start_f), .abort(1'b0),
    .dut_in(dut_in_f), .dut_out(dut_out_f), .busy(busy_f), .table_out(table_f),
    .result_valid(rv_f), .pass(pass_f), .mismatch(mm_f)
  );

  // Reference gate: output high only for vectors 001 and 011.
  function automatic logic gate(input logic [2:0] v);
    return (v == 3'd1) || (v == 3'd3);
  endfunction

  // Three-cycle propagation delay for the slow-gate model.
  always @(posedge clk) begin
    d1 <= dut_in;   d2 <= d1; d3 <= d2;
    f1 <= dut_in_f; f2 <= f1; f3 <= f2;
  end

  always_comb begin
    case (mode)
      1:       dut_out = 1'b1;
      2:       dut_out = gate(d3);
      default: dut_out = gate(dut_in);
    endcase
    dut_out_f = gate(f3);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Runs a sweep on u_dut. Cycle n is sampled 1ns after the n-th rising
  // edge following the start request (edge 1 accepts start). Optional
  // extra start pulses, and an abort or reset request at a given cycle,
  // at which point the task returns with that input still asserted.
  task automatic sweep(input int sa1, input int sa2, input int ab_at, input int rs_at,
                       output int lat, output int din_err);
    int cnt;
    cnt = 0; lat = 0; din_err = 0;
    @(negedge clk);
    start = 1'b1;
    while ((cnt < 150) && (lat == 0)) begin
      @(posedge clk); #1;
      cnt++;
      start = (cnt == sa1) || (cnt == sa2);
      abort = (cnt == ab_at);
      reset = (cnt == rs_at);
      if (result_valid) lat = cnt;
      else if (busy && (dut_in != 3'((cnt - 1) / 5))) din_err++;
      if ((cnt == ab_at) || (cnt == rs_at)) break;
    end
  endtask

  typedef struct {
    int         mode;
    logic [7:0] tbl;
    logic       ps;
    logic [7:0] mm;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int lat, de, pulses;

    vecs[0] = '{mode: 0, tbl: 8'h0A, ps: 1'b1, mm: 8'h00};
    vecs[1] = '{mode: 1, tbl: 8'hFF, ps: 1'b0, mm: 8'hF5};
    vecs[2] = '{mode: 2, tbl: 8'h0A, ps: 1'b1, mm: 8'h00};

    reset = 1'b1; start = 1'b0; abort = 1'b0; start_f = 1'b0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dut_in", 32'(dut_in), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_table", 32'(table_out), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_mismatch", 32'(mismatch), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Table-driven sweeps over the gate models.
    for (int i = 0; i < 3; i++) begin
      mode = vecs[i].mode;
      sweep(0, 0, 0, 0, lat, de);
      check($sformatf("v%0d_latency", i), lat, 41);
      check($sformatf("v%0d_dut_in_steps", i), de, 0);
      check($sformatf("v%0d_table", i), 32'(table_out), 32'(vecs[i].tbl));
      check($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].ps));
      check($sformatf("v%0d_mismatch", i), 32'(mismatch), 32'(vecs[i].mm));
      check($sformatf("v%0d_busy_done", i), 32'(busy), 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_pulse_end", i), 32'(result_valid), 0);
      check($sformatf("v%0d_pass_held", i), 32'(pass), 32'(vecs[i].ps));
      repeat (3) @(posedge clk);
    end

    // Short settle against the slow gate: rows see the previous vector.
    @(negedge clk);
    start_f = 1'b1;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start_f = 1'b0;
      if (rv_f) begin lat = c; break; end
    end
    check("fast_latency", lat, 17);
    check("fast_table", 32'(table_f), 32'h14);
    check("fast_pass", 32'(pass_f), 0);
    check("fast_mismatch", 32'(mm_f), 32'h1E);

    // start and abort together in IDLE: abort wins.
    mode = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check("start_abort_idle", 32'(busy), 0);
    start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);

    // Extra start requests while busy are dropped.
    sweep(5, 20, 0, 0, lat, de);
    check("busy_start_latency", lat, 41);
    check("busy_start_steps", de, 0);
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (result_valid || busy) pulses++;
    end
    check("busy_start_no_rerun", pulses, 0);

    // Abort mid-sweep (pass was 1 from the previous run).
    sweep(0, 0, 12, 0, lat, de);
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_dut_in", 32'(dut_in), 0);
    abort = 1'b0;
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
    end
    check("abort_no_result", pulses, 0);
    check("abort_pass", 32'(pass), 0);
    check("abort_mismatch", 32'(mismatch), 0);
    sweep(0, 0, 0, 0, lat, de);
    check("after_abort_latency", lat, 41);
    check("after_abort_table", 32'(table_out), 32'h0A);
    check("after_abort_pass", 32'(pass), 1);
    repeat (3) @(posedge clk);

    // Reset mid-sweep.
    sweep(0, 0, 0, 17, lat, de);
    check("pre_reset_partial", 32'(table_out), 32'h02);
    @(posedge clk); #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_dut_in", 32'(dut_in), 0);
    check("mid_rst_table", 32'(table_out), 0);
    check("mid_rst_valid", 32'(result_valid), 0);
    check("mid_rst_pass", 32'(pass), 0);
    check("mid_rst_mismatch", 32'(mismatch), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    sweep(0, 0, 0, 0, lat, de);
    check("after_rst_latency", lat, 41);
    check("after_rst_steps", de, 0);
    check("after_rst_table", 32'(table_out), 32'h0A);
    check("after_rst_pass", 32'(pass), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
